// File: rtl/fusion_test_pkg.sv
// Shared types and constants for the sensor fusion front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fusion_test_pkg;

   localparam int DATA_WIDTH            = 16;
   localparam int ALIGN_TIMEOUT_DEFAULT = 64;

   // One aligned IMU/LIDAR pair; valid qualifies the whole word.
   typedef struct packed {
      logic [DATA_WIDTH-1:0] imu;
      logic [DATA_WIDTH-1:0] lidar;
      logic                  valid;
   } sensor_input_t;

   // IDLE: nothing buffered, WAIT: one side buffered and counting, EMIT: output pending.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_EMIT = 2'd2
   } aligner_state_e;

   // Saturating 16-bit increment used by the pair counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Generic synchronous FIFO holding one sensor's samples.
// Latency: a sample pushed at edge E is at the head from edge E+1.
// Backpressure: full blocks pushes, pops on empty are ignored.
module sample_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [DATA_WIDTH-1:0]         push_data,
   input  logic                          pop,
   output logic [DATA_WIDTH-1:0]         head_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   // The extra pointer bit tells a full ring from an empty one.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count     = wr_ptr - rd_ptr;
   assign head_data = mem[rd_ptr[AW-1:0]];
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;

   // Pointer update; reset discards all buffered samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents are meaningless until the pointers say otherwise.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/sensor_aligner.sv
// Pairs IMU and LIDAR samples into one output word, filling a side from its last value on timeout.
// Latency: samples accepted at edge E into empty FIFOs appear on out_data after edge E+1.
// Backpressure: out_data holds while !out_ready; per-side ready drops when that side's FIFO is full.
module sensor_aligner
   import fusion_test_pkg::*;
#(
   parameter int DATA_WIDTH     = fusion_test_pkg::DATA_WIDTH,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = ALIGN_TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  imu_valid,
   input  logic [DATA_WIDTH-1:0] imu_data,
   output logic                  imu_ready,
   input  logic                  lidar_valid,
   input  logic [DATA_WIDTH-1:0] lidar_data,
   output logic                  lidar_ready,
   output sensor_input_t         out_data,
   input  logic                  out_ready,
   output logic                  stale_imu,
   output logic                  stale_lidar,
   output logic [15:0]           pair_count
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

   aligner_state_e        state;
   logic                  in_en;
   logic [TW-1:0]         wait_cnt;
   logic [DATA_WIDTH-1:0] held_imu;
   logic [DATA_WIDTH-1:0] held_lidar;

   logic [DATA_WIDTH-1:0] imu_head,  lidar_head;
   logic                  imu_full,  lidar_full;
   logic                  imu_empty, lidar_empty;
   logic [CNTW-1:0]       imu_count, lidar_count;
   logic                  imu_push,  lidar_push;
   logic                  imu_pop,   lidar_pop;

   logic load_ok, one_side, do_fresh, do_stale, emit;
   logic next_out_valid, imu_next_nonempty, lidar_next_nonempty;

   // Inputs stay blocked through reset and open on the first edge after release.
   assign imu_ready   = in_en && !imu_full;
   assign lidar_ready = in_en && !lidar_full;
   assign imu_push    = imu_valid && imu_ready;
   assign lidar_push  = lidar_valid && lidar_ready;

   // The output register can take a new word when nothing is pending or it is being taken now.
   assign load_ok  = (state != ST_EMIT) || out_ready;
   assign one_side = imu_empty ^ lidar_empty;
   assign do_fresh = enable && load_ok && !imu_empty && !lidar_empty;
   assign do_stale = enable && load_ok && one_side && (wait_cnt == TO_MAX);
   assign emit     = do_fresh || do_stale;
   assign imu_pop   = do_fresh || (do_stale && !imu_empty);
   assign lidar_pop = do_fresh || (do_stale && !lidar_empty);

   // Occupancy after this edge, used to choose the next FSM state.
   assign next_out_valid      = emit || (out_data.valid && !out_ready);
   assign imu_next_nonempty   = imu_push   || (imu_count   != CNTW'(imu_pop));
   assign lidar_next_nonempty = lidar_push || (lidar_count != CNTW'(lidar_pop));

   sample_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_imu_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (imu_push),
      .push_data (imu_data),
      .pop       (imu_pop),
      .head_data (imu_head),
      .full      (imu_full),
      .empty     (imu_empty),
      .count     (imu_count)
   );

   sample_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_lidar_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (lidar_push),
      .push_data (lidar_data),
      .pop       (lidar_pop),
      .head_data (lidar_head),
      .full      (lidar_full),
      .empty     (lidar_empty),
      .count     (lidar_count)
   );

   // Alignment FSM with its registered outputs, timeout counter and held stale-fill values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         in_en       <= 1'b0;
         wait_cnt    <= '0;
         held_imu    <= '0;
         held_lidar  <= '0;
         out_data    <= '0;
         stale_imu   <= 1'b0;
         stale_lidar <= 1'b0;
         pair_count  <= '0;
      end else begin
         in_en <= 1'b1;

         // Count only while exactly one side waits; hold at the limit while the output is blocked.
         if (emit || !enable || !one_side)
            wait_cnt <= '0;
         else if (wait_cnt != TO_MAX)
            wait_cnt <= wait_cnt + TW'(1);

         if (do_fresh) begin
            out_data    <= '{imu: imu_head, lidar: lidar_head, valid: 1'b1};
            stale_imu   <= 1'b0;
            stale_lidar <= 1'b0;
            held_imu    <= imu_head;
            held_lidar  <= lidar_head;
            pair_count  <= sat_inc16(pair_count);
         end else if (do_stale) begin
            if (!imu_empty) begin
               out_data    <= '{imu: imu_head, lidar: held_lidar, valid: 1'b1};
               stale_imu   <= 1'b0;
               stale_lidar <= 1'b1;
               held_imu    <= imu_head;
            end else begin
               out_data    <= '{imu: held_imu, lidar: lidar_head, valid: 1'b1};
               stale_imu   <= 1'b1;
               stale_lidar <= 1'b0;
               held_lidar  <= lidar_head;
            end
         end else if (out_ready) begin
            out_data.valid <= 1'b0;
         end

         if (next_out_valid)
            state <= ST_EMIT;
         else if (imu_next_nonempty || lidar_next_nonempty)
            state <= ST_WAIT;
         else
            state <= ST_IDLE;
      end
   end

endmodule

// File: tb/tb_sensor_aligner.sv
// Self-checking bench for sensor_aligner: queue-based reference model plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_sensor_aligner;
   import fusion_test_pkg::*;

   localparam int DEPTH = 4;
   localparam int TO    = 64;

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic          imu_valid;
   logic [15:0]   imu_data;
   logic          imu_ready;
   logic          lidar_valid;
   logic [15:0]   lidar_data;
   logic          lidar_ready;
   sensor_input_t out_data;
   logic          out_ready;
   logic          stale_imu;
   logic          stale_lidar;
   logic [15:0]   pair_count;

   int total = 0;
   int bad   = 0;

   sensor_aligner #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .imu_valid   (imu_valid),
      .imu_data    (imu_data),
      .imu_ready   (imu_ready),
      .lidar_valid (lidar_valid),
      .lidar_data  (lidar_data),
      .lidar_ready (lidar_ready),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .stale_imu   (stale_imu),
      .stale_lidar (stale_lidar),
      .pair_count  (pair_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] qi[$];
   logic [15:0] ql[$];
   bit          m_en, m_ov, m_si, m_sl;
   logic [15:0] m_oi, m_ol, m_hi, m_hl;
   int          m_pc, m_wait;
   bit          r_i, r_l, ld, ne_i, ne_l, fr, st;

   always begin
      @(posedge clk);
      if (!rst_n) begin
         qi.delete(); ql.delete();
         m_en = 0; m_ov = 0; m_si = 0; m_sl = 0;
         m_oi = '0; m_ol = '0; m_hi = '0; m_hl = '0;
         m_pc = 0; m_wait = 0;
      end else begin
         r_i  = m_en && (qi.size() < DEPTH);
         r_l  = m_en && (ql.size() < DEPTH);
         ld   = !m_ov || out_ready;
         ne_i = qi.size() > 0;
         ne_l = ql.size() > 0;
         fr   = enable && ld && ne_i && ne_l;
         st   = enable && ld && (ne_i != ne_l) && (m_wait >= TO - 1);
         if (fr) begin
            m_oi = qi.pop_front(); m_ol = ql.pop_front();
            m_ov = 1; m_si = 0; m_sl = 0;
            m_hi = m_oi; m_hl = m_ol;
            if (m_pc < 65535) m_pc++;
         end else if (st) begin
            m_ov = 1;
            if (ne_i) begin
               m_oi = qi.pop_front(); m_ol = m_hl; m_si = 0; m_sl = 1; m_hi = m_oi;
            end else begin
               m_ol = ql.pop_front(); m_oi = m_hi; m_si = 1; m_sl = 0; m_hl = m_ol;
            end
         end else if (ld) begin
            m_ov = 0;
         end
         // Cycles spent with exactly one side waiting alone, capped at the timeout point.
         if (fr || st)                      m_wait = 0;
         else if (enable && (ne_i != ne_l)) m_wait = (m_wait < TO - 1) ? m_wait + 1 : m_wait;
         else                               m_wait = 0;
         // Samples pushed this edge are not visible to this edge's pairing decision.
         if (imu_valid && r_i)   qi.push_back(imu_data);
         if (lidar_valid && r_l) ql.push_back(lidar_data);
         m_en = 1;
      end
      #1;
      chk("imu_ready",   imu_ready,      m_en && (qi.size() < DEPTH));
      chk("lidar_ready", lidar_ready,    m_en && (ql.size() < DEPTH));
      chk("out_valid",   out_data.valid, m_ov);
      chk("pair_count",  pair_count,     m_pc);
      if (m_ov) begin
         chk("out_imu",     out_data.imu,   m_oi);
         chk("out_lidar",   out_data.lidar, m_ol);
         chk("stale_imu",   stale_imu,      m_si);
         chk("stale_lidar", stale_lidar,    m_sl);
      end
   end

   // ---------------- directed stimulus ----------------
   logic [15:0] got_i[8];
   logic [15:0] got_l[8];
   int          n_got;
   int          seen;

   initial begin
      rst_n = 1'b0; enable = 1'b1; out_ready = 1'b1;
      imu_valid = 1'b0; lidar_valid = 1'b0; imu_data = '0; lidar_data = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_out_data",   out_data,   '0);
      chk("rst_imu_ready",  imu_ready,  1'b0);
      chk("rst_lid_ready",  lidar_ready, 1'b0);
      chk("rst_pair_count", pair_count, 16'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", imu_ready, 1'b1);

      // Fresh pair, one-cycle latency.
      imu_valid = 1; imu_data = 16'h0011; lidar_valid = 1; lidar_data = 16'h0022;
      @(negedge clk);
      imu_valid = 0; lidar_valid = 0;
      chk("pair_latency_not_yet", out_data.valid, 1'b0);
      @(negedge clk);
      chk("pair_valid", out_data.valid, 1'b1);
      chk("pair_imu",   out_data.imu,   16'h0011);
      chk("pair_lidar", out_data.lidar, 16'h0022);
      chk("pair_stale", {stale_imu, stale_lidar}, 2'b00);
      chk("pair_count1", pair_count, 16'd1);

      // IMU alone until timeout: stale LIDAR fill from last pair.
      imu_valid = 1; imu_data = 16'h0033;
      @(negedge clk);
      imu_valid = 0;
      repeat (63) @(negedge clk);
      chk("timeout_not_early", out_data.valid, 1'b0);
      @(negedge clk);
      chk("timeout_valid", out_data.valid, 1'b1);
      chk("timeout_imu",   out_data.imu,   16'h0033);
      chk("timeout_lidar", out_data.lidar, 16'h0022);
      chk("timeout_stale", {stale_imu, stale_lidar}, 2'b01);
      chk("timeout_count", pair_count, 16'd1);
      @(negedge clk);

      // Blocked output: five pairs fill register plus FIFO, then release in order.
      out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         chk("fill_ready", imu_ready && lidar_ready, 1'b1);
         imu_valid = 1; imu_data = 16'h0100 + 16'(i);
         lidar_valid = 1; lidar_data = 16'h0200 + 16'(i);
         @(negedge clk);
      end
      imu_valid = 0; lidar_valid = 0;
      chk("full_imu_ready", imu_ready,   1'b0);
      chk("full_lid_ready", lidar_ready, 1'b0);
      out_ready = 1;
      n_got = 0;
      repeat (8) begin
         if (out_data.valid && out_ready && n_got < 8) begin
            got_i[n_got] = out_data.imu;
            got_l[n_got] = out_data.lidar;
            n_got++;
         end
         @(negedge clk);
      end
      chk("drain_count", n_got, 5);
      for (int i = 0; i < 5; i++) begin
         chk("drain_imu",   got_i[i], 16'h0100 + 16'(i));
         chk("drain_lidar", got_l[i], 16'h0200 + 16'(i));
      end

      // Disabled: buffered pair stays put, then emits fresh once enabled.
      enable = 0;
      imu_valid = 1; imu_data = 16'h0044; lidar_valid = 1; lidar_data = 16'h0055;
      @(negedge clk);
      imu_valid = 0; lidar_valid = 0;
      repeat (100) @(negedge clk);
      chk("disabled_no_emit", out_data.valid, 1'b0);
      enable = 1;
      @(negedge clk);
      chk("enabled_valid", out_data.valid, 1'b1);
      chk("enabled_imu",   out_data.imu,   16'h0044);
      chk("enabled_lidar", out_data.lidar, 16'h0055);
      chk("enabled_stale", {stale_imu, stale_lidar}, 2'b00);
      @(negedge clk);

      // Mid-operation reset with output pending and three samples buffered.
      out_ready = 0;
      imu_valid = 1; imu_data = 16'h00A1; lidar_valid = 1; lidar_data = 16'h00A2;
      @(negedge clk);
      imu_data = 16'h00B1; lidar_valid = 0;
      @(negedge clk);
      imu_data = 16'h00C1; lidar_valid = 1; lidar_data = 16'h00D2;
      @(negedge clk);
      imu_valid = 0; lidar_valid = 0;
      chk("pre_rst_pending", out_data.valid, 1'b1);
      rst_n = 0;
      #1;
      chk("midrst_out_data", out_data, '0);
      chk("midrst_stale",    {stale_imu, stale_lidar}, 2'b00);
      chk("midrst_count",    pair_count, 16'd0);
      chk("midrst_ready",    {imu_ready, lidar_ready}, 2'b00);
      @(negedge clk);
      rst_n = 1; out_ready = 1;
      seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (out_data.valid) seen++;
      end
      chk("post_rst_no_emit", seen, 0);

      // Saturation: 65535 back-to-back pairs, then one more.
      imu_valid = 1; lidar_valid = 1;
      for (int i = 0; i < 65535; i++) begin
         imu_data = 16'(i); lidar_data = ~16'(i);
         @(negedge clk);
      end
      imu_valid = 0; lidar_valid = 0;
      repeat (3) @(negedge clk);
      chk("sat_count_ffff", pair_count, 16'hFFFF);
      imu_valid = 1; imu_data = 16'h0E01; lidar_valid = 1; lidar_data = 16'h0E02;
      @(negedge clk);
      imu_valid = 0; lidar_valid = 0;
      @(negedge clk);
      chk("sat_extra_valid", out_data.valid, 1'b1);
      chk("sat_extra_imu",   out_data.imu,   16'h0E01);
      chk("sat_count_held",  pair_count,     16'hFFFF);
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
